// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 keyboard command decoder:
// prefix FSM states, prefix bytes, idle command and the scan-to-command map.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [5:0] CMD_IDLE       = 6'h0C;

  // Returns {hit, cmd}; hit is low for any key that has no command.
  function automatic logic [6:0] ps2_map(input logic ext, input logic [7:0] code);
    logic [6:0] r;
    r = 7'h00;
    if (!ext) begin
      case (code)
        8'h16:   r = {1'b1, 6'h00};
        8'h1E:   r = {1'b1, 6'h10};
        8'h26:   r = {1'b1, 6'h20};
        8'h25:   r = {1'b1, 6'h30};
        8'h2D:   r = {1'b1, 6'h01};
        8'h34:   r = {1'b1, 6'h02};
        8'h32:   r = {1'b1, 6'h03};
        default: r = 7'h00;
      endcase
    end else begin
      case (code)
        8'h75:   r = {1'b1, 6'h04};
        8'h72:   r = {1'b1, 6'h05};
        8'h6B:   r = {1'b1, 6'h06};
        8'h74:   r = {1'b1, 6'h07};
        default: r = 7'h00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_cmd_decoder_if.sv
// Scan-byte input and command output bundle of the PS/2 command decoder.
// Handshake: scan_valid is a one-cycle strobe with no back-pressure; a command
// transfers on every rising edge where cmd_valid and cmd_ready are both high,
// cmd is stable while cmd_valid is high and not accepted.
interface ps2_key_cmd_decoder_if #(
  parameter int CMD_W = 6
);
  logic [7:0]       scan_code;
  logic             scan_valid;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             cmd_ready;

  // master: the decoder (command source); slave: receiver/consumer side
  modport master (input scan_code, scan_valid, cmd_ready, output cmd, cmd_valid);
  modport slave  (output scan_code, scan_valid, cmd_ready, input cmd, cmd_valid);
endinterface

// File: rtl/ps2_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two so
// the pointers wrap naturally. A push while full is accepted only with a pop.
module ps2_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_cmd_decoder.sv
// PS/2 scan-code to VGA command decoder: prefix FSM, key map, command FIFO.
// Optional typematic-repeat suppression is enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_key_cmd_decoder
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_W      = 6,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  ps2_key_cmd_decoder_if.master       bus,
  output logic                        overflow,
  output logic [LVL_W-1:0]            level,
  output ps2_state_t                  state
);

  logic             is_ext_byte;
  logic             is_brk_byte;
  logic             is_data;
  logic             data_ext;
  logic             data_brk;
  logic [6:0]       map_res;
  logic             make_hit;
  logic             push_req;
  logic             pop;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] push_data;
  logic [CMD_W-1:0] idle_cmd;
  logic [CMD_W-1:0] head;

  assign is_ext_byte = bus.scan_valid && (bus.scan_code == PS2_PREFIX_EXT);
  assign is_brk_byte = bus.scan_valid && (bus.scan_code == PS2_PREFIX_BRK);
  assign is_data     = bus.scan_valid && !is_ext_byte && !is_brk_byte;
  assign data_ext    = (state == EXT) || (state == EXT_BRK);
  assign data_brk    = (state == BRK) || (state == EXT_BRK);
  assign map_res     = ps2_map(data_ext, bus.scan_code);
  assign make_hit    = is_data && !data_brk && map_res[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (is_ext_byte) begin
      state <= EXT;
    end else if (is_brk_byte) begin
      case (state)
        IDLE:    state <= BRK;
        EXT:     state <= EXT_BRK;
        default: state <= state;
      endcase
    end else if (is_data) begin
      state <= IDLE;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] held_key;
  logic       held_valid;
  logic [8:0] key_now;
  logic       held_match;

  assign key_now    = {data_ext, bus.scan_code};
  assign held_match = held_valid && (held_key == key_now);
  assign push_req   = make_hit && !held_match;

  // Only mapped makes are ever held, so only their breaks can release it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_key   <= '0;
      held_valid <= 1'b0;
    end else if (push_req) begin
      held_key   <= key_now;
      held_valid <= 1'b1;
    end else if (is_data && data_brk && held_match) begin
      held_valid <= 1'b0;
    end
  end
`else
  assign push_req = make_hit;
`endif

  always_comb begin
    push_data      = '0;
    push_data[5:0] = map_res[5:0];
    idle_cmd       = '0;
    idle_cmd[5:0]  = CMD_IDLE;
  end

  assign pop       = bus.cmd_valid && bus.cmd_ready;
  assign fifo_push = push_req && (!fifo_full || pop);

  ps2_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign bus.cmd_valid = !fifo_empty;
  assign bus.cmd       = fifo_empty ? idle_cmd : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_cmd_decoder.sv
// Self-checking bench for ps2_key_cmd_decoder: directed scenarios followed by
// random byte streams, all checked against a queue-based behavioural model.
module tb_ps2_key_cmd_decoder;
  import ps2_key_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 6;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          overflow;
  logic [LW-1:0] level;
  ps2_state_t    dbg_state;

  ps2_key_cmd_decoder_if #(.CMD_W(CW)) bus ();

  ps2_key_cmd_decoder #(
    .FIFO_DEPTH (DEPTH),
    .CMD_W      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .overflow (overflow),
    .level    (level),
    .state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [CW-1:0] exp_q[$];
  int            cmd_map[logic [8:0]];
  bit            m_ext, m_brk, m_ovf;
  bit            m_held_v;
  logic [8:0]    m_held;
  int            n_checks, n_fail;
  logic [7:0]    mapped_codes[11] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2D, 8'h34,
                                      8'h32, 8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0]    odd_codes[4] = '{8'hAA, 8'hFA, 8'hEE, 8'hE1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [CW-1:0] exp_cmd;
    exp_cmd = (exp_q.size() > 0) ? exp_q[0] : 6'h0C;
    check_eq({tag, "_cmd"},   32'(bus.cmd), 32'(exp_cmd));
    check_eq({tag, "_valid"}, 32'(bus.cmd_valid), 32'(exp_q.size() > 0));
    check_eq({tag, "_level"}, 32'(level), 32'(exp_q.size()));
    check_eq({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_held_v = 0; m_held = '0;
  endtask

  // Asserted between edges; outputs must be at reset values while it is held.
  task automatic apply_reset();
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.cmd_ready  = 1'b0;
    reset = 1'b1;
    model_clear();
    #2;
    check_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy, input string tag);
    bit         pop, push_req;
    logic [8:0] key;
    bus.scan_valid = v;
    bus.scan_code  = b;
    bus.cmd_ready  = rdy;
    pop      = rdy && (exp_q.size() > 0);
    push_req = 0;
    key      = '0;
    if (v) begin
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        key = {m_ext, b};
        if (!m_brk && cmd_map.exists(key)) begin
`ifdef PS2_REPEAT_FILTER_EN
          if (!(m_held_v && m_held == key)) begin
            push_req = 1; m_held = key; m_held_v = 1;
          end
`else
          push_req = 1;
`endif
        end else if (m_brk) begin
`ifdef PS2_REPEAT_FILTER_EN
          if (m_held_v && m_held == key) m_held_v = 0;
`endif
        end
        m_ext = 0; m_brk = 0;
      end
    end
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (push_req) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(CW'(cmd_map[key]));
      else m_ovf = 1;
    end
    bus.scan_valid = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmd_map[{1'b0, 8'h16}] = 'h00; cmd_map[{1'b0, 8'h1E}] = 'h10;
    cmd_map[{1'b0, 8'h26}] = 'h20; cmd_map[{1'b0, 8'h25}] = 'h30;
    cmd_map[{1'b0, 8'h2D}] = 'h01; cmd_map[{1'b0, 8'h34}] = 'h02;
    cmd_map[{1'b0, 8'h32}] = 'h03;
    cmd_map[{1'b1, 8'h75}] = 'h04; cmd_map[{1'b1, 8'h72}] = 'h05;
    cmd_map[{1'b1, 8'h6B}] = 'h06; cmd_map[{1'b1, 8'h74}] = 'h07;

    reset = 1'b1;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.cmd_ready  = 1'b0;
    #7;
    apply_reset();

    // single make, then pop back to idle
    step(1, 8'h2D, 0, "make_r");
    check_eq("tp_first_cmd", 32'(bus.cmd), 32'h01);
    check_eq("tp_first_level", 32'(level), 32'd1);
    step(0, 8'h00, 1, "pop_r");
    check_eq("tp_pop_idle", 32'(bus.cmd), 32'h0C);

    // break suppressed, following make pushed
    step(1, 8'hF0, 0, "brk_pfx");
    step(1, 8'h2D, 0, "brk_r");
    check_eq("tp_break_level", 32'(level), 32'd0);
    step(1, 8'h34, 0, "make_g");
    check_eq("tp_make_g", 32'(bus.cmd), 32'h02);
    step(0, 8'h00, 1, "pop_g");

    // extended make, extended break, bare 75
    step(1, 8'hE0, 0, "ext1");
    step(1, 8'h75, 0, "ext_up");
    step(1, 8'hE0, 0, "ext2");
    step(1, 8'hF0, 0, "ext_brk");
    step(1, 8'h75, 0, "ext_up_rel");
    step(1, 8'h75, 0, "plain_75");
    check_eq("tp_ext_level", 32'(level), 32'd1);
    check_eq("tp_ext_cmd", 32'(bus.cmd), 32'h04);
    step(0, 8'h00, 1, "pop_up");

    // typematic repeat sequence
    apply_reset();
    step(1, 8'h16, 0, "rep1");
    step(1, 8'h16, 0, "rep2");
    step(1, 8'h16, 0, "rep3");
    step(1, 8'hF0, 0, "rep_brk");
    step(1, 8'h16, 0, "rep_rel");
    step(1, 8'h16, 0, "rep4");
`ifdef PS2_REPEAT_FILTER_EN
    check_eq("tp_repeat_level", 32'(level), 32'd2);
`else
    check_eq("tp_repeat_level", 32'(level), 32'd4);
`endif

    // overflow with FIFO full, then simultaneous push and pop at full
    apply_reset();
    step(1, 8'h2D, 0, "ov1");
    step(1, 8'h34, 0, "ov2");
    step(1, 8'h32, 0, "ov3");
    step(1, 8'h16, 0, "ov4");
    step(1, 8'h1E, 0, "ov5");
    check_eq("tp_ovf_level", 32'(level), 32'd4);
    check_eq("tp_ovf_flag", 32'(overflow), 32'd1);
    check_eq("tp_ovf_head", 32'(bus.cmd), 32'h01);
    step(1, 8'h25, 1, "ov_pushpop");
    check_eq("tp_pp_level", 32'(level), 32'd4);
    check_eq("tp_pp_head", 32'(bus.cmd), 32'h02);

    // reset discards a pending E0 prefix; strobe-low bytes are ignored
    apply_reset();
    step(1, 8'hE0, 0, "pre_rst_e0");
    apply_reset();
    step(1, 8'h72, 0, "post_rst_72");
    check_eq("tp_rst_prefix", 32'(level), 32'd0);
    step(0, 8'h2D, 0, "no_strobe");
    check_eq("tp_no_strobe", 32'(level), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int         r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:          b = 8'hE0;
        2:             b = 8'hF0;
        3, 4, 5, 6:    b = mapped_codes[$urandom_range(0, 10)];
        7:             b = odd_codes[$urandom_range(0, 3)];
        default:       b = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 2) == 0), "rnd");
      if (i == 1500) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
